// File: rtl/morse_seq_detect_if.sv
// Bus bundle for morse_seq_detect: keyed input line plus letter/sequence outputs.
interface morse_seq_detect_if #(
    parameter int MATCH_W = 8
);
    logic               in;
    logic               cb;
    logic               is;
    logic               letter_valid;
    logic [6:0]         letter_code;
    logic               letter_err;
    logic [MATCH_W-1:0] match_count;

    modport master (
        output in,
        input  cb, is, letter_valid, letter_code, letter_err, match_count
    );

    modport slave (
        input  in,
        output cb, is, letter_valid, letter_code, letter_err, match_count
    );
endinterface

// File: rtl/morse_seq_detect.sv
// Morse letter decoder and sequence detector on a sampled keyed line.
// Define MORSE_OVERLAP_EN to let a finished match seed the next one.
module morse_seq_detect #(
    parameter int                       DOT_MAX     = 2,
    parameter int                       DASH_MAX    = 6,
    parameter int                       LETTER_GAP  = 4,
    parameter int                       NUM_LETTERS = 3,
    parameter logic [7*NUM_LETTERS-1:0] PATTERN     = 21'hC1BB0,
    parameter int                       MATCH_W     = 8
) (
    input  logic                clk,
    input  logic                rst,
    morse_seq_detect_if.slave   bus
);
    localparam int MW = $clog2(DASH_MAX + 2);
    localparam int GW = $clog2(LETTER_GAP + 1);
    localparam int IW = (NUM_LETTERS > 1) ? $clog2(NUM_LETTERS) : 1;

    localparam logic [MW-1:0] MARK_SAT = MW'(DASH_MAX + 1);
    localparam logic [MW-1:0] DOT_LIM  = MW'(DOT_MAX);
    localparam logic [MW-1:0] DASH_LIM = MW'(DASH_MAX);
    localparam logic [GW-1:0] GAP_SAT  = GW'(LETTER_GAP);
    localparam logic [IW-1:0] LAST_IDX = IW'(NUM_LETTERS - 1);

`ifdef MORSE_OVERLAP_EN
    localparam logic [IW-1:0] RELOAD_IDX =
        (PATTERN[6:0] == PATTERN[7*(NUM_LETTERS-1) +: 7]) ? IW'(1) : IW'(0);
`else
    localparam logic [IW-1:0] RELOAD_IDX = IW'(0);
`endif

    logic [6:0]         pat_s [NUM_LETTERS];

    logic [MW-1:0]      mark_r, mark_nx_s;
    logic [GW-1:0]      gap_r, gap_nx_s;
    logic [3:0]         sym_r, sym_nx_s;
    logic [2:0]         len_r, len_nx_s;
    logic               bad_r, bad_nx_s;
    logic [IW-1:0]      idx_r, idx_nx_s;
    logic               done_s, valid_s, err_s, hit_s;
    logic [6:0]         code_s;

    logic               cb_r, is_r, letter_valid_r, letter_err_r;
    logic [6:0]         letter_code_r;
    logic [MATCH_W-1:0] match_count_r;

    for (genvar g = 0; g < NUM_LETTERS; g++) begin : g_pat
        assign pat_s[g] = PATTERN[7*g +: 7];
    end

    // Run counters, symbol buffer and letter-completion detection.
    always_comb begin
        mark_nx_s = mark_r;
        gap_nx_s  = gap_r;
        sym_nx_s  = sym_r;
        len_nx_s  = len_r;
        bad_nx_s  = bad_r;
        done_s    = 1'b0;
        if (bus.in) begin
            gap_nx_s = {GW{1'b0}};
            if (mark_r != MARK_SAT) begin
                mark_nx_s = mark_r + MW'(1);
            end else begin
                mark_nx_s = mark_r;
            end
        end else begin
            if (mark_r != {MW{1'b0}}) begin
                mark_nx_s = {MW{1'b0}};
                if (mark_r > DASH_LIM) begin
                    bad_nx_s = 1'b1;
                end else if (len_r == 3'd4) begin
                    bad_nx_s = 1'b1;
                end else begin
                    sym_nx_s[len_r[1:0]] = (mark_r > DOT_LIM);
                    len_nx_s             = len_r + 3'd1;
                end
            end else begin
                mark_nx_s = mark_r;
            end
            // Saturated gap means idle: nothing further happens on low input.
            if (gap_r != GAP_SAT) begin
                gap_nx_s = gap_r + GW'(1);
                done_s   = (gap_nx_s == GAP_SAT) && ((len_nx_s != 3'd0) || bad_nx_s);
            end else begin
                gap_nx_s = gap_r;
            end
        end
    end

    // Progress through the target sequence on each completed letter.
    always_comb begin
        code_s   = {len_nx_s, sym_nx_s};
        idx_nx_s = idx_r;
        valid_s  = 1'b0;
        err_s    = 1'b0;
        hit_s    = 1'b0;
        if (done_s) begin
            if (bad_nx_s) begin
                err_s    = 1'b1;
                idx_nx_s = {IW{1'b0}};
            end else begin
                valid_s = 1'b1;
                if (code_s == pat_s[idx_r]) begin
                    if (idx_r == LAST_IDX) begin
                        hit_s    = 1'b1;
                        idx_nx_s = RELOAD_IDX;
                    end else begin
                        idx_nx_s = idx_r + IW'(1);
                    end
                end else if (code_s == pat_s[0]) begin
                    idx_nx_s = IW'(1);
                end else begin
                    idx_nx_s = {IW{1'b0}};
                end
            end
        end else begin
            idx_nx_s = idx_r;
        end
    end

    // State and output registers; gap starts saturated so idle input is silent.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mark_r         <= {MW{1'b0}};
            gap_r          <= GAP_SAT;
            sym_r          <= 4'd0;
            len_r          <= 3'd0;
            bad_r          <= 1'b0;
            idx_r          <= {IW{1'b0}};
            cb_r           <= 1'b0;
            is_r           <= 1'b0;
            letter_valid_r <= 1'b0;
            letter_err_r   <= 1'b0;
            letter_code_r  <= 7'd0;
            match_count_r  <= {MATCH_W{1'b0}};
        end else begin
            mark_r <= mark_nx_s;
            gap_r  <= gap_nx_s;
            if (done_s) begin
                sym_r <= 4'd0;
                len_r <= 3'd0;
                bad_r <= 1'b0;
            end else begin
                sym_r <= sym_nx_s;
                len_r <= len_nx_s;
                bad_r <= bad_nx_s;
            end
            idx_r          <= idx_nx_s;
            cb_r           <= (idx_nx_s != {IW{1'b0}});
            is_r           <= hit_s;
            letter_valid_r <= valid_s;
            letter_err_r   <= err_s;
            if (valid_s) begin
                letter_code_r <= code_s;
            end else begin
                letter_code_r <= letter_code_r;
            end
            if (hit_s) begin
                match_count_r <= match_count_r + MATCH_W'(1);
            end else begin
                match_count_r <= match_count_r;
            end
        end
    end

    assign bus.cb           = cb_r;
    assign bus.is           = is_r;
    assign bus.letter_valid = letter_valid_r;
    assign bus.letter_err   = letter_err_r;
    assign bus.letter_code  = letter_code_r;
    assign bus.match_count  = match_count_r;
endmodule

// File: tb/tb_morse_seq_detect.sv
// Directed bench for morse_seq_detect with default parameters (dot=1, dash=4 high cycles).
module tb_morse_seq_detect;
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    morse_seq_detect_if #(.MATCH_W(8)) bus ();
    morse_seq_detect dut (.clk(clk), .rst(rst), .bus(bus));

`ifdef MORSE_OVERLAP_EN
    localparam int OVL = 1;
`else
    localparam int OVL = 0;
`endif

    int total  = 0;
    int passed = 0;
    int failed = 0;
    int lv_cnt = 0;
    int err_cnt = 0;
    int is_cnt = 0;
    int is_lv_cnt = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic v);
        bus.in = v;
        @(posedge clk);
        #1;
        if (bus.letter_valid === 1'b1) lv_cnt++;
        if (bus.letter_err === 1'b1) err_cnt++;
        if (bus.is === 1'b1) is_cnt++;
        if (bus.is === 1'b1 && bus.letter_valid === 1'b1) is_lv_cnt++;
    endtask

    task automatic mark(input int n);
        repeat (n) send(1'b1);
    endtask

    task automatic gap(input int n);
        repeat (n) send(1'b0);
    endtask

    task automatic letter(input int n, input logic [3:0] sym);
        for (int i = 0; i < n; i++) begin
            mark(sym[i] ? 4 : 1);
            if (i < n - 1) gap(1);
        end
        gap(4);
    endtask

    task automatic let_s();
        letter(3, 4'b0000);
    endtask

    task automatic let_o();
        letter(3, 4'b0111);
    endtask

    task automatic release_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        lv_cnt = 0;
        err_cnt = 0;
        is_cnt = 0;
        is_lv_cnt = 0;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        bus.in = 1'b0;
        release_reset();
    endtask

    initial begin
        bus.in = 1'b0;
        rst = 1'b0;
        #12;
        chk("rst_cb", 32'(bus.cb), 32'd0);
        chk("rst_is", 32'(bus.is), 32'd0);
        chk("rst_lv", 32'(bus.letter_valid), 32'd0);
        chk("rst_err", 32'(bus.letter_err), 32'd0);
        chk("rst_code", 32'(bus.letter_code), 32'h00);
        chk("rst_mc", 32'(bus.match_count), 32'd0);
        release_reset();

        gap(8);
        chk("idle_no_letter", 32'(lv_cnt + err_cnt), 32'd0);

        let_s();
        chk("sos1_lv", 32'(lv_cnt), 32'd1);
        chk("sos1_code", 32'(bus.letter_code), 32'h30);
        chk("sos1_cb", 32'(bus.cb), 32'd1);
        let_o();
        chk("sos2_lv", 32'(lv_cnt), 32'd2);
        chk("sos2_code", 32'(bus.letter_code), 32'h37);
        chk("sos2_is", 32'(is_cnt), 32'd0);
        let_s();
        chk("sos3_code", 32'(bus.letter_code), 32'h30);
        chk("sos3_is", 32'(is_cnt), 32'd1);
        chk("sos3_is_with_lv", 32'(is_lv_cnt), 32'd1);
        chk("sos3_mc", 32'(bus.match_count), 32'd1);
        chk("sos3_cb", 32'(bus.cb), 32'(OVL));

        // Dot/dash boundaries and letter-gap timing.
        do_reset();
        mark(2); gap(1); mark(3); gap(1); mark(6); gap(4);
        chk("bnd_code", 32'(bus.letter_code), 32'h36);
        chk("bnd_err", 32'(err_cnt), 32'd0);
        mark(1); gap(3);
        chk("gap3_no_letter", 32'(lv_cnt), 32'd1);
        gap(1);
        chk("gap4_letter", 32'(lv_cnt), 32'd2);
        chk("e_code", 32'(bus.letter_code), 32'h10);
        letter(4, 4'b0000);
        chk("four_dots_code", 32'(bus.letter_code), 32'h40);

        // SOSOS overlap behaviour.
        do_reset();
        let_s(); let_o(); let_s(); let_o(); let_s();
        chk("sosos_is", 32'(is_cnt), 32'(1 + OVL));
        chk("sosos_mc", 32'(bus.match_count), 32'(1 + OVL));
        chk("sosos_cb", 32'(bus.cb), 32'd1);

        // Over-length mark and sustained high.
        do_reset();
        let_s();
        mark(7); gap(4);
        chk("long_err", 32'(err_cnt), 32'd1);
        chk("long_code", 32'(bus.letter_code), 32'h30);
        chk("long_cb", 32'(bus.cb), 32'd0);
        chk("long_is", 32'(is_cnt), 32'd0);
        mark(30); gap(3);
        chk("stuck_no_err_yet", 32'(err_cnt), 32'd1);
        gap(1);
        chk("stuck_err", 32'(err_cnt), 32'd2);
        gap(10);
        chk("idle_quiet", 32'(err_cnt + lv_cnt), 32'd3);

        // Five symbols in one letter.
        do_reset();
        for (int i = 0; i < 5; i++) begin
            mark(1);
            if (i < 4) gap(1);
        end
        gap(4);
        chk("five_err", 32'(err_cnt), 32'd1);
        chk("five_lv", 32'(lv_cnt), 32'd0);
        let_s(); let_o(); let_s();
        chk("five_then_is", 32'(is_cnt), 32'd1);
        chk("five_then_mc", 32'(bus.match_count), 32'd1);

        // Mismatch recovery.
        do_reset();
        let_s(); let_o(); let_o();
        chk("soo_cb", 32'(bus.cb), 32'd0);
        let_s(); let_o(); let_s();
        chk("soosos_is", 32'(is_cnt), 32'd1);
        chk("soosos_mc", 32'(bus.match_count), 32'd1);
        do_reset();
        let_s(); let_s();
        chk("ss_cb", 32'(bus.cb), 32'd1);
        let_o(); let_s();
        chk("ssos_is", 32'(is_cnt), 32'd1);
        chk("ssos_mc", 32'(bus.match_count), 32'd1);

        // Reset in the middle of a letter.
        do_reset();
        let_s(); let_o(); let_s();
        let_s();
        mark(4); gap(1); mark(2);
        rst = 1'b0;
        bus.in = 1'b0;
        #1;
        chk("mid_rst_cb", 32'(bus.cb), 32'd0);
        chk("mid_rst_mc", 32'(bus.match_count), 32'd0);
        chk("mid_rst_code", 32'(bus.letter_code), 32'h00);
        chk("mid_rst_pulses", 32'({bus.is, bus.letter_valid, bus.letter_err}), 32'd0);
        release_reset();
        let_o(); let_s();
        chk("after_rst_no_is", 32'(is_cnt), 32'd0);
        let_s(); let_o(); let_s();
        chk("after_rst_is", 32'(is_cnt), 32'd1);
        chk("after_rst_mc", 32'(bus.match_count), 32'd1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/morse_seq_detect.md
MORSE_SEQ_DETECT -- requirements
Module: morse_seq_detect

Interface
REQ-001 SHALL have parameter DOT_MAX, default 2: longest high run (cycles) classed as a dot.
REQ-002 SHALL have parameter DASH_MAX, default 6: longest high run classed as a dash; must exceed DOT_MAX.
REQ-003 SHALL have parameter LETTER_GAP, default 4: low-run length (cycles) that ends a letter.
REQ-004 SHALL have parameter NUM_LETTERS, default 3: letters in target sequence, range 2..8.
REQ-005 SHALL have parameter PATTERN, width 7*NUM_LETTERS, default 21'hC1BB0 ("SOS"): letter k in bits [7k+6:7k], each {len[2:0], sym[3:0]}, sym[0] first, dot=0, dash=1.
REQ-006 SHALL have parameter MATCH_W, default 8: width of match_count.
REQ-007 clk  input  1  single clock, rising edge.
REQ-008 rst  input  1  asynchronous, active-low reset.
REQ-009 in  input  1  serial keyed line, sampled every clk.
REQ-010 cb  output  1  high while a valid sequence prefix has been received.
REQ-011 is  output  1  one-cycle pulse: complete sequence received.
REQ-012 letter_valid  output  1  one-cycle pulse: a well-formed letter just completed.
REQ-013 letter_code  output  7  {len, sym} of last completed letter; held until the next letter completes.
REQ-014 letter_err  output  1  one-cycle pulse: a malformed letter just completed.
REQ-015 match_count  output  MATCH_W  number of complete matches, wraps at 2^MATCH_W.

Function
REQ-016 SHALL count consecutive high cycles in a mark counter saturating at DASH_MAX+1; on the falling edge, length 1..DOT_MAX appends a dot, DOT_MAX+1..DASH_MAX a dash, and >DASH_MAX flags the letter bad.
REQ-017 SHALL count consecutive low cycles in a gap counter saturating at LETTER_GAP; a low run shorter than LETTER_GAP keeps subsequent marks in the same letter.
REQ-018 SHALL complete a letter on the rising clock edge where the gap counter reaches LETTER_GAP and at least one mark is pending; the outputs of REQ-012..REQ-014 and REQ-019..REQ-022 update on that same edge.
REQ-019 SHALL flag a letter bad if it contains more than 4 symbols; a bad letter pulses letter_err (not letter_valid), leaves letter_code unchanged and returns the progress index to 0.
REQ-020 SHALL keep a progress index 0..NUM_LETTERS-1; a valid letter equal to PATTERN[idx] advances idx; a mismatch sets idx to 1 if the letter equals PATTERN[0], else 0.
REQ-021 SHALL, when a valid letter matches PATTERN[NUM_LETTERS-1] at idx=NUM_LETTERS-1, pulse is for one cycle, increment match_count and reload idx per REQ-031/REQ-032.
REQ-022 SHALL drive cb = (idx != 0), registered; cb is 0 in the cycle is pulses unless overlap reload sets idx to 1.
REQ-023 SHALL ignore further low cycles once the gap counter saturates (no repeated letter events during idle).
REQ-024 SHALL treat a sustained high line as one over-length mark; it is reported as letter_err only after the following LETTER_GAP low cycles.
REQ-025 SHALL produce all outputs from registers; no combinational path from in to any output.

Reset
REQ-026 SHALL, while rst=0, asynchronously clear cb, is, letter_valid, letter_err, letter_code, match_count, idx, both run counters and the symbol buffer.
REQ-027 SHALL initialise the gap counter saturated after reset, so idle low input after reset produces no letter.
REQ-028 SHALL discard any partial letter or partial sequence when reset asserts mid-operation.
REQ-029 SHALL resume sampling on the first rising clk after rst deasserts.

Configuration
REQ-030 SHALL use preprocessor macro MORSE_OVERLAP_EN.
REQ-031 With MORSE_OVERLAP_EN defined, after a complete match idx SHALL reload to 1 if PATTERN[NUM_LETTERS-1] equals PATTERN[0] (so "SOSOS" yields two matches), else 0.
REQ-032 Without MORSE_OVERLAP_EN, after a complete match idx SHALL reload to 0 (so "SOSOS" yields one match).

Verification (defaults; dot = 1 high cycle, dash = 4, intra gap = 1 low, letter gap = 4 low)
REQ-033 Reset, then S,O,S -> letter_valid pulses with codes 7'h30, 7'h37, 7'h30; cb high after the first S; is pulses once on the third letter edge; match_count=1.
REQ-034 S,O,S,O,S -> with MORSE_OVERLAP_EN: is twice, match_count=2, cb=1 after first is; without: is once, match_count=1.
REQ-035 S, then mark of 7 high cycles, then 4 low -> letter_err pulses, letter_code stays 7'h30, cb falls to 0, no is.
REQ-036 Five dots in one letter -> letter_err pulses; then S,O,S -> is pulses; match_count=1.
REQ-037 S,O,O,S,O,S -> mismatch on second O sets idx=0, final S,O,S -> is once; S,S,O,S -> is once (mismatch S reloads idx=1).
REQ-038 rst low during O of S,O,S -> all outputs 0 immediately; subsequent O,S gives no is; fresh S,O,S gives is, match_count=1.
